// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared types and helpers for the multi-port register file
package regfile_mp_pkg;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } sweep_state_e;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/scoreboard bus of the multi-port register file
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic                 clr_req;
  logic                 rdy;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic [NRD-1:0]       rd_busy;

  modport master (
    output clr_req, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rdy, rd_data, rd_busy
  );

  modport slave (
    input  clr_req, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rdy, rd_data, rd_busy
  );

endinterface

// File: rtl/regfile_mp_sweep.sv
// rtl/regfile_mp_sweep.sv - zeroing sweep FSM: walks reg[1..NREGS-1] after reset or clear request
module regfile_sweep_ctrl
  import regfile_mp_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req_i,
  output logic          rdy_o,
  output logic          sweep_we_o,
  output logic [AW-1:0] sweep_addr_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  sweep_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SWEEP;
      cnt_q   <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdy_o        = 1'b0;
    sweep_we_o   = 1'b0;
    sweep_addr_o = cnt_q;
    case (state_q)
      ST_SWEEP: begin
        sweep_we_o = 1'b1;
        cnt_d      = cnt_q + FIRST_IDX;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = FIRST_IDX;
        end
      end
      ST_RUN: begin
        rdy_o = 1'b1;
        if (clr_req_i) begin
          state_d = ST_SWEEP;
          cnt_d   = FIRST_IDX;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        cnt_d   = FIRST_IDX;
      end
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write-to-read bypass and zeroing sweep
// Optional pending-write scoreboard enabled by defining RF_SCOREBOARD_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave rf
);

  localparam int AW = rf_aw(NREGS);

  logic                rdy;
  logic                sweep_we;
  logic [AW-1:0]       sweep_addr;
  logic [NRD-1:0]      hit;
  logic [NRD*XLEN-1:0] rd_data;

  // Storage deliberately has no reset so it maps onto distributed RAM.
  logic [XLEN-1:0] mem_q [NREGS];

  regfile_sweep_ctrl #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sweep (
    .clk          (clk),
    .rst          (rst),
    .clr_req_i    (rf.clr_req),
    .rdy_o        (rdy),
    .sweep_we_o   (sweep_we),
    .sweep_addr_o (sweep_addr)
  );

  assign rf.rdy = rdy;

  // Later write ports overwrite earlier ones, so port NWR-1 wins on a collision.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_addr] <= '0;
    end else if (rdy) begin
      for (int k = 0; k < NWR; k++) begin
        if (rf.wr_en[k] && (rf.wr_addr[k*AW +: AW] != '0)) begin
          mem_q[rf.wr_addr[k*AW +: AW]] <= rf.wr_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    hit     = '0;
    for (int p = 0; p < NRD; p++) begin
      if (rdy && (rf.rd_addr[p*AW +: AW] != '0)) begin
        rd_data[p*XLEN +: XLEN] = mem_q[rf.rd_addr[p*AW +: AW]];
        for (int k = 0; k < NWR; k++) begin
          if (rf.wr_en[k] && (rf.wr_addr[k*AW +: AW] == rf.rd_addr[p*AW +: AW])) begin
            rd_data[p*XLEN +: XLEN] = rf.wr_data[k*XLEN +: XLEN];
            hit[p]                  = 1'b1;
          end
        end
      end
    end
  end

  assign rf.rd_data = rd_data;

`ifdef RF_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;
  logic [NRD-1:0]   rd_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Reserve is applied after the write clears, so a same-cycle reserve keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (!rdy || rf.clr_req) begin
      busy_d = '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (rf.wr_en[k]) begin
          busy_d[rf.wr_addr[k*AW +: AW]] = 1'b0;
        end
      end
      if (rf.rsv_en && (rf.rsv_addr != '0)) begin
        busy_d[rf.rsv_addr] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_busy[p] = busy_q[rf.rd_addr[p*AW +: AW]] & ~hit[p];
    end
  end

  assign rf.rd_busy = rd_busy;
`else
  logic unused_sb;
  assign unused_sb  = ^{rf.rsv_en, rf.rsv_addr, hit};
  assign rf.rd_busy = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (vector table + expectation queue)
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  typedef struct {
    int          id;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        rsv;
    logic [4:0]  rsva;
    logic        clr;
    logic        erdy;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } rec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  rec_t exp_q[$];
  rec_t vec[11];

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) rf_bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(input int id, input logic [1:0] we,
                              input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] e0, input logic [31:0] e1);
    rec_t r;
    r.id = id;   r.we = we;
    r.wa0 = wa0; r.wd0 = wd0; r.wa1 = wa1; r.wd1 = wd1;
    r.ra0 = ra0; r.ra1 = ra1;
    r.rsv = 1'b0; r.rsva = 5'd0; r.clr = 1'b0;
    r.erdy = 1'b1; r.e0 = e0; r.e1 = e1; r.eb = 2'b00;
    return r;
  endfunction

  task automatic drive_idle();
    rf_bus.clr_req  = 1'b0;
    rf_bus.wr_en    = '0;
    rf_bus.wr_addr  = '0;
    rf_bus.wr_data  = '0;
    rf_bus.rd_addr  = '0;
    rf_bus.rsv_en   = 1'b0;
    rf_bus.rsv_addr = '0;
  endtask

  task automatic step(input string nm, input rec_t r);
    rec_t e;
    @(posedge clk);
    #1;
    rf_bus.wr_en    = r.we;
    rf_bus.wr_addr  = {r.wa1, r.wa0};
    rf_bus.wr_data  = {r.wd1, r.wd0};
    rf_bus.rd_addr  = {r.ra1, r.ra0};
    rf_bus.rsv_en   = r.rsv;
    rf_bus.rsv_addr = r.rsva;
    rf_bus.clr_req  = r.clr;
    exp_q.push_back(r);
    #3;
    e = exp_q.pop_front();
    check($sformatf("%s%0d_rdy", nm, e.id), 32'(rf_bus.rdy), 32'(e.erdy));
    check($sformatf("%s%0d_rd0", nm, e.id), rf_bus.rd_data[31:0], e.e0);
    check($sformatf("%s%0d_rd1", nm, e.id), rf_bus.rd_data[63:32], e.e1);
    check($sformatf("%s%0d_busy", nm, e.id), 32'(rf_bus.rd_busy), SB ? 32'(e.eb) : 32'd0);
  endtask

  // Counts clock edges until rdy rises; inputs are left as the caller set them.
  task automatic wait_rdy(input string nm, input int exp_cycles);
    int n;
    n = 0;
    while (!rf_bus.rdy && n < 200) begin
      @(posedge clk);
      #4;
      n++;
    end
    check(nm, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    rec_t r;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive_idle();
    rf_bus.rd_addr = {5'd7, 5'd5};

    vec[0]  = mk(0,  2'b01, 5'd5,  32'hDEADBEEF, 5'd0, 32'h0,    5'd5,  5'd0,  32'hDEADBEEF, 32'h0);
    vec[1]  = mk(1,  2'b00, 5'd0,  32'h0,        5'd0, 32'h0,    5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF);
    vec[2]  = mk(2,  2'b01, 5'd0,  32'h1234,     5'd0, 32'h0,    5'd0,  5'd5,  32'h0,        32'hDEADBEEF);
    vec[3]  = mk(3,  2'b00, 5'd0,  32'h0,        5'd0, 32'h0,    5'd0,  5'd0,  32'h0,        32'h0);
    vec[4]  = mk(4,  2'b11, 5'd7,  32'h11,       5'd7, 32'h22,   5'd7,  5'd7,  32'h22,       32'h22);
    vec[5]  = mk(5,  2'b00, 5'd0,  32'h0,        5'd0, 32'h0,    5'd7,  5'd5,  32'h22,       32'hDEADBEEF);
    vec[6]  = mk(6,  2'b11, 5'd8,  32'hAAAA,     5'd9, 32'hBBBB, 5'd8,  5'd9,  32'hAAAA,     32'hBBBB);
    vec[7]  = mk(7,  2'b10, 5'd8,  32'hDDDD,     5'd8, 32'hCCCC, 5'd8,  5'd9,  32'hCCCC,     32'hBBBB);
    vec[8]  = mk(8,  2'b00, 5'd0,  32'h0,        5'd0, 32'h0,    5'd8,  5'd31, 32'hCCCC,     32'h0);
    vec[9]  = mk(9,  2'b01, 5'd31, 32'hFFFFFFFF, 5'd0, 32'h0,    5'd31, 5'd1,  32'hFFFFFFFF, 32'h0);
    vec[10] = mk(10, 2'b00, 5'd0,  32'h0,        5'd0, 32'h0,    5'd31, 5'd8,  32'hFFFFFFFF, 32'hCCCC);

    // Reset state and initial sweep length.
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", 32'(rf_bus.rdy), 32'd0);
    check("reset_rd0", rf_bus.rd_data[31:0], 32'd0);
    check("reset_busy", 32'(rf_bus.rd_busy), 32'd0);
    rst = 1'b1;
    wait_rdy("init_sweep_len", 31);

    for (int i = 1; i < NREGS; i++) begin
      step("zero", mk(i, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(i), 5'(NREGS - i), 32'h0, 32'h0));
    end

    for (int i = 0; i < 11; i++) begin
      step("vec", vec[i]);
    end

    // Clear request: same-cycle write performed, sweep-time writes/reserves dropped.
    step("clr", mk(0, 2'b01, 5'd3, 32'hA5, 5'd0, 32'h0, 5'd3, 5'd0, 32'hA5, 32'h0));
    r = mk(1, 2'b01, 5'd10, 32'h77, 5'd0, 32'h0, 5'd3, 5'd10, 32'hA5, 32'h77);
    r.clr = 1'b1;
    step("clr", r);
    r = mk(2, 2'b01, 5'd4, 32'h1, 5'd0, 32'h0, 5'd3, 5'd4, 32'h0, 32'h0);
    r.rsv = 1'b1; r.rsva = 5'd4; r.erdy = 1'b0;
    step("clr", r);
    wait_rdy("clr_sweep_len", 31);
    drive_idle();
    step("clr", mk(3, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd4, 32'h0, 32'h0));
    step("clr", mk(4, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd5, 32'h0, 32'h0));

    // Asynchronous reset part-way through a sweep restarts the full count.
    step("rsw", mk(0, 2'b01, 5'd6, 32'h66, 5'd0, 32'h0, 5'd6, 5'd0, 32'h66, 32'h0));
    r = mk(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 5'd0, 32'h66, 32'h0);
    r.clr = 1'b1;
    step("rsw", r);
    @(posedge clk);
    #1;
    drive_idle();
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #2;
    check("midsweep_reset_rdy", 32'(rf_bus.rdy), 32'd0);
    #2;
    rst = 1'b1;
    wait_rdy("rst_sweep_len", 31);
    step("rsw", mk(2, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 5'd31, 32'h0, 32'h0));

    // Pending-write scoreboard.
    r = mk(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 32'h0, 32'h0);
    r.rsv = 1'b1; r.rsva = 5'd9;
    step("sb", r);
    r = mk(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 32'h0, 32'h0);
    r.eb = 2'b11;
    step("sb", r);
    step("sb", mk(2, 2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 5'd9, 5'd9, 32'h55, 32'h55));
    step("sb", mk(3, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 32'h55, 32'h55));
    r = mk(4, 2'b10, 5'd0, 32'h0, 5'd9, 32'h66, 5'd9, 5'd3, 32'h66, 32'h0);
    r.rsv = 1'b1; r.rsva = 5'd9;
    step("sb", r);
    r = mk(5, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 32'h66, 32'h66);
    r.eb = 2'b11;
    step("sb", r);
    r = mk(6, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 32'h66, 32'h0);
    r.rsv = 1'b1; r.rsva = 5'd0; r.eb = 2'b01;
    step("sb", r);
    r = mk(7, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd9, 32'h0, 32'h66);
    r.eb = 2'b10;
    step("sb", r);
    r = mk(8, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 32'h66, 32'h66);
    r.clr = 1'b1; r.eb = 2'b11;
    step("sb", r);
    r = mk(9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 32'h0, 32'h0);
    r.erdy = 1'b0;
    step("sb", r);
    wait_rdy("sb_sweep_len", 31);
    step("sb", mk(10, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 32'h0, 32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
